// File: rtl/bandai2003_pkg.sv
// bandai2003_pkg: constants and state encoding shared by the unlock controller and cartridge side
package bandai2003_pkg;
  localparam logic [7:0] ADDR_ACK = 8'h5A;
  localparam logic [7:0] ADDR_NAK = 8'hA5;
  localparam logic [7:0] ADDR_NIL = 8'h00;
  localparam int FRAME_W = 20;
  localparam logic [FRAME_W-1:0] FRAME_DEF = 20'h14503;
  typedef enum logic [2:0] {IDLE, RSTP, ACK, NAK, RECV, CHECK} state_t;
endpackage

// File: rtl/bandai2003_sipo.sv
// bandai2003_sipo: LSB-first serial-in shift register with bit counter
module bandai2003_sipo
  import bandai2003_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_si,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_full
);
  localparam logic [4:0] LAST = 5'(FRAME_W - 1);
  logic [4:0] r_cnt;
  // o_full flags the shift that completes the frame so the FSM can leave RECV on that edge
  assign o_full = i_en && r_cnt == LAST;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      o_frame <= {i_si, o_frame[FRAME_W-1:1]};
      r_cnt   <= r_cnt + 5'd1;
    end
  end
endmodule

// File: rtl/bandai2003_unlock_ctrl.sv
// bandai2003_unlock_ctrl: console-side cartridge unlock sequencer with bounded retries
module bandai2003_unlock_ctrl
  import bandai2003_pkg::*;
#(
  parameter int                 RST_CYC = 4,
  parameter int                 RETRIES = 2,
  parameter logic [FRAME_W-1:0] EXPECT  = FRAME_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_si,
  output logic [7:0]         o_addr,
  output logic               o_cart_rst_n,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_unlocked,
  output logic [FRAME_W-1:0] o_frame
);
  localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
  localparam logic [7:0]  ATT_MAX  = 8'(RETRIES);
  state_t      r_state;
  logic [15:0] r_rst_cnt;
  logic [7:0]  r_att;
  logic        w_full;
  bandai2003_sipo u_sipo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (r_state == NAK),
    .i_en    (r_state == RECV),
    .i_si    (i_si),
    .o_frame (o_frame),
    .o_full  (w_full)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      o_addr       <= ADDR_NIL;
      o_cart_rst_n <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_unlocked   <= 1'b0;
      r_rst_cnt    <= '0;
      r_att        <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          o_unlocked   <= 1'b0;
          r_att        <= '0;
          r_rst_cnt    <= '0;
          o_cart_rst_n <= 1'b0;
          o_busy       <= 1'b1;
          r_state      <= RSTP;
        end
        RSTP: if (r_rst_cnt == RST_LAST) begin
          o_cart_rst_n <= 1'b1;
          o_addr       <= ADDR_ACK;
          r_state      <= ACK;
        end else r_rst_cnt <= r_rst_cnt + 16'd1;
        ACK: begin
          o_addr  <= ADDR_NAK;
          r_state <= NAK;
        end
        NAK: begin
          o_addr  <= ADDR_NIL;
          r_state <= RECV;
        end
        RECV: if (w_full) r_state <= CHECK;
        CHECK: if (o_frame == EXPECT) begin
          o_unlocked <= 1'b1;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          r_state    <= IDLE;
        end else if (r_att < ATT_MAX) begin
          r_att        <= r_att + 8'd1;
          r_rst_cnt    <= '0;
          o_cart_rst_n <= 1'b0;
          r_state      <= RSTP;
        end else begin
          o_err   <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bandai2003_unlock_ctrl.sv
// tb_bandai2003_unlock_ctrl: randomized runs against a cartridge model and an outcome-level reference
module tb_bandai2003_unlock_ctrl;
  localparam int RST_CYC = 4;
  localparam int RETRIES = 2;
  localparam logic [19:0] EXPECT = 20'h14503;
  localparam int RUN_LEN = RST_CYC + 23;
  logic        i_clk = 0, i_rst = 1, i_start = 0, i_si = 1;
  logic [7:0]  o_addr;
  logic        o_cart_rst_n, o_busy, o_done, o_err, o_unlocked;
  logic [19:0] o_frame;
  int n_vec = 0, n_err = 0;
  logic [19:0] tx [RETRIES+1];
  int          tx_i = 0;
  bit          force_one = 0, armed = 0, illegal = 0;
  logic [19:0] sh = '1;
  logic [7:0]  prev_addr = 8'h00;

  bandai2003_unlock_ctrl #(.RST_CYC(RST_CYC), .RETRIES(RETRIES), .EXPECT(EXPECT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_si(i_si),
    .o_addr(o_addr), .o_cart_rst_n(o_cart_rst_n), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_unlocked(o_unlocked), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cartridge: loads its frame on the edge that ends the A5h cycle, then shifts it out LSB first
  always @(negedge i_clk) armed = (o_addr == 8'hA5);
  always @(posedge i_clk) begin
    #1;
    if (!o_cart_rst_n) begin
      sh = '1;
      i_si = force_one ? 1'b1 : 1'($urandom);
    end else begin
      if (armed) begin
        sh = tx_i <= RETRIES ? tx[tx_i] : EXPECT;
        tx_i++;
      end else sh = {1'b1, sh[19:1]};
      i_si = force_one ? 1'b1 : sh[0];
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) prev_addr = 8'h00;
    else begin
      if (!(o_addr inside {8'h00, 8'h5A, 8'hA5})) illegal = 1;
      if (o_addr == 8'hA5 && prev_addr != 8'h5A) illegal = 1;
      if (prev_addr == 8'h5A && o_addr != 8'hA5) illegal = 1;
      prev_addr = o_addr;
    end
  end

  task automatic run(input string tag, input int noise_e);
    int k, e, phases, exp_e;
    logic [19:0] f, last;
    bit prev_n;
    k = -1;
    last = '0;
    for (int i = 0; i <= RETRIES; i++) begin
      f = force_one ? 20'hFFFFF : tx[i];
      if (k < 0) last = f;
      if (k < 0 && f == EXPECT) k = i;
    end
    exp_e = (k < 0 ? RETRIES + 1 : k + 1) * RUN_LEN;
    tx_i = 0;
    illegal = 0;
    @(negedge i_clk) i_start = 1;
    @(posedge i_clk) #2 i_start = 0;
    e = 0;
    chk({tag, " busy_e0"}, o_busy, 1);
    phases = !o_cart_rst_n;
    prev_n = o_cart_rst_n;
    while (!(o_done || o_err) && e < 400) begin
      if (noise_e > 0 && e == noise_e - 1) i_start = 1;
      @(posedge i_clk) #2;
      e++;
      if (noise_e > 0 && e == noise_e) i_start = 0;
      if (prev_n && !o_cart_rst_n) phases++;
      prev_n = o_cart_rst_n;
      if (e == RST_CYC) chk({tag, " addr_ack"}, o_addr, 8'h5A);
      if (e == RST_CYC + 1) chk({tag, " addr_nak"}, o_addr, 8'hA5);
    end
    chk({tag, " end_edge"}, e, exp_e);
    chk({tag, " done"}, o_done, k >= 0);
    chk({tag, " err"}, o_err, k < 0);
    chk({tag, " unlocked"}, o_unlocked, k >= 0);
    chk({tag, " frame"}, o_frame, last);
    chk({tag, " rst_phases"}, phases, k < 0 ? RETRIES + 1 : k + 1);
    chk({tag, " busy_end"}, o_busy, 0);
    chk({tag, " addr_legal"}, illegal, 0);
    @(posedge i_clk) #2;
    chk({tag, " pulse_len"}, o_done | o_err, 0);
    chk({tag, " unlocked_sticky"}, o_unlocked, k >= 0);
  endtask

  initial begin
    #12;
    chk("rst_addr", o_addr, 0);
    chk("rst_cart_rst_n", o_cart_rst_n, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done_err", {o_done, o_err}, 0);
    chk("rst_unlocked", o_unlocked, 0);
    chk("rst_frame", o_frame, 0);
    @(negedge i_clk) i_rst = 0;
    repeat (2) @(negedge i_clk);
    foreach (tx[i]) tx[i] = EXPECT;
    run("nominal", 0);
    run("start_busy", 10);
    force_one = 1;
    run("bad_frame", 0);
    force_one = 0;
    tx[0] = EXPECT ^ 20'h00100;
    run("recovery", 0);
    tx[0] = EXPECT;
    tx_i = 0;
    @(negedge i_clk) i_start = 1;
    @(posedge i_clk) #2 i_start = 0;
    repeat (RST_CYC + 8) @(posedge i_clk);
    #3 i_rst = 1;
    #1;
    chk("midrst_addr", o_addr, 0);
    chk("midrst_cart_rst_n", o_cart_rst_n, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_frame", o_frame, 0);
    @(negedge i_clk) i_rst = 0;
    @(negedge i_clk);
    run("after_rst", 0);
    for (int r = 0; r < 12; r++) begin
      force_one = ($urandom % 6) == 0;
      foreach (tx[i]) tx[i] = ($urandom % 2) ? EXPECT : EXPECT ^ (20'd1 << ($urandom % 20));
      run("random", ($urandom % 2) ? int'($urandom_range(2, 20)) : 0);
      repeat ($urandom % 3) @(negedge i_clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
